// File: rtl/conv_tile_loader.sv
// conv_tile_loader
// Upstream stage of dsp_conv_chip. Takes one 72-bit valid/ready command stream
// and scatters its contents to the conv tiles. Image words go to the per-tile
// URAM1 write ports. Kernel weights go to the per-tile kernel BRAM1/BRAM2 ports.
// Address and data buses are shared by all tiles; a one-hot enable picks the
// destination tile.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   s_data/s_valid/s_ready   command stream (header word, then N payload words)
//   uram1_wr_addr/data/en    shared URAM1 write bus, one-hot tile enable
//   krnl_wraddr/wrdata       shared kernel BRAM write bus
//   krnl_bram1_wren/2_wren   one-hot per-bank tile enables
//   done                     pulse with the last write (or last dropped word) of a packet
//   err                      pulse one cycle after an illegal header is accepted
module conv_tile_loader #(
  parameter int Y        = 480,
  parameter int A_W      = 14,
  parameter int M_W      = 18,
  parameter int URAM_D_W = 72,
  parameter int URAM_A_W = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [URAM_D_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [URAM_A_W-1:0] uram1_wr_addr,
  output logic [URAM_D_W-1:0] uram1_wr_data,
  output logic [Y-1:0]        uram1_wr_en,
  output logic [A_W-1:0]      krnl_wraddr,
  output logic [M_W-1:0]      krnl_wrdata,
  output logic [Y-1:0]        krnl_bram1_wren,
  output logic [Y-1:0]        krnl_bram2_wren,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {HDR, IMG, KRN, DROP} state_t;

  state_t state, state_nxt;

  logic                rst_q;
  logic [11:0]         tile_q;
  logic                bank2_q;
  logic [URAM_A_W-1:0] addr_q;
  logic [15:0]         cnt_q;
  logic [1:0]          lanes_q;
  logic [3*M_W-1:0]    lane_buf_q;

  logic [1:0]          hdr_type;
  logic [11:0]         hdr_tile;
  logic [22:0]         hdr_base;
  logic [15:0]         hdr_n;
  logic                hdr_illegal;
  logic                accept;
  logic [Y-1:0]        tile_onehot;

  assign hdr_type    = s_data[71:70];
  assign hdr_tile    = s_data[69:58];
  assign hdr_base    = s_data[57:35];
  assign hdr_n       = s_data[34:19];
  assign hdr_illegal = (hdr_type == 2'd3) || ({1'b0, hdr_tile} >= 13'(Y));
  assign accept      = s_valid && s_ready;
  assign tile_onehot = {{(Y-1){1'b0}}, 1'b1} << tile_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= HDR;
    else     state <= state_nxt;
  end

  // Next-state logic. In KRN the packet ends when lane 3 of the last
  // word goes out, i.e. no words left and one lane still pending.
  always_comb begin
    state_nxt = state;
    case (state)
      HDR: begin
        if (accept) begin
          if (hdr_n == 16'd0)          state_nxt = HDR;
          else if (hdr_illegal)        state_nxt = DROP;
          else if (hdr_type == 2'd0)   state_nxt = IMG;
          else                         state_nxt = KRN;
        end
      end
      IMG:  if (accept && cnt_q == 16'd1) state_nxt = HDR;
      KRN:  if (lanes_q == 2'd1 && cnt_q == 16'd0) state_nxt = HDR;
      DROP: if (accept && cnt_q == 16'd1) state_nxt = HDR;
      default: state_nxt = HDR;
    endcase
  end

  // Output logic: ready is held low in the cycle after reset, and in KRN
  // while lanes 1..3 of the buffered word are still being written.
  always_comb begin
    s_ready = 1'b0;
    if (!rst_q) begin
      case (state)
        KRN:     s_ready = (lanes_q == 2'd0);
        default: s_ready = 1'b1;
      endcase
    end
  end

  // Datapath: header latching, address/count tracking and the registered
  // write buses. Buses keep their last value when no enable is raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q           <= 1'b1;
      tile_q          <= '0;
      bank2_q         <= 1'b0;
      addr_q          <= '0;
      cnt_q           <= '0;
      lanes_q         <= '0;
      lane_buf_q      <= '0;
      uram1_wr_addr   <= '0;
      uram1_wr_data   <= '0;
      uram1_wr_en     <= '0;
      krnl_wraddr     <= '0;
      krnl_wrdata     <= '0;
      krnl_bram1_wren <= '0;
      krnl_bram2_wren <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      rst_q           <= 1'b0;
      uram1_wr_en     <= '0;
      krnl_bram1_wren <= '0;
      krnl_bram2_wren <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
      case (state)
        HDR: begin
          if (accept) begin
            tile_q  <= hdr_tile;
            bank2_q <= (hdr_type == 2'd2);
            addr_q  <= URAM_A_W'(hdr_base);
            cnt_q   <= hdr_n;
            lanes_q <= '0;
            if (hdr_illegal)            err  <= 1'b1;
            else if (hdr_n == 16'd0)    done <= 1'b1;
          end
        end
        IMG: begin
          if (accept) begin
            uram1_wr_en   <= tile_onehot;
            uram1_wr_addr <= addr_q;
            uram1_wr_data <= s_data;
            addr_q        <= addr_q + 1'b1;
            cnt_q         <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) done <= 1'b1;
          end
        end
        KRN: begin
          // Lane 0 is written straight from the stream; lanes 1..3 are
          // shifted out of lane_buf_q on the following cycles.
          if (accept) begin
            if (bank2_q) krnl_bram2_wren <= tile_onehot;
            else         krnl_bram1_wren <= tile_onehot;
            krnl_wraddr <= addr_q[A_W-1:0];
            krnl_wrdata <= s_data[M_W-1:0];
            lane_buf_q  <= s_data[4*M_W-1:M_W];
            addr_q      <= addr_q + 1'b1;
            cnt_q       <= cnt_q - 16'd1;
            lanes_q     <= 2'd3;
          end else if (lanes_q != 2'd0) begin
            if (bank2_q) krnl_bram2_wren <= tile_onehot;
            else         krnl_bram1_wren <= tile_onehot;
            krnl_wraddr <= addr_q[A_W-1:0];
            krnl_wrdata <= lane_buf_q[M_W-1:0];
            lane_buf_q  <= lane_buf_q >> M_W;
            addr_q      <= addr_q + 1'b1;
            lanes_q     <= lanes_q - 2'd1;
            if (lanes_q == 2'd1 && cnt_q == 16'd0) done <= 1'b1;
          end
        end
        DROP: begin
          if (accept) begin
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_loader.sv
// tb_conv_tile_loader
// Directed bench for conv_tile_loader. Stimulus pushes expected write/done/err
// events into a queue; a monitor on the falling edge pops and compares each
// time the DUT raises any enable, done or err.
module tb_conv_tile_loader;

  localparam int Y        = 480;
  localparam int A_W      = 14;
  localparam int M_W      = 18;
  localparam int URAM_D_W = 72;
  localparam int URAM_A_W = 23;

  logic                clk;
  logic                rst;
  logic [URAM_D_W-1:0] s_data;
  logic                s_valid;
  logic                s_ready;
  logic [URAM_A_W-1:0] uram1_wr_addr;
  logic [URAM_D_W-1:0] uram1_wr_data;
  logic [Y-1:0]        uram1_wr_en;
  logic [A_W-1:0]      krnl_wraddr;
  logic [M_W-1:0]      krnl_wrdata;
  logic [Y-1:0]        krnl_bram1_wren;
  logic [Y-1:0]        krnl_bram2_wren;
  logic                done;
  logic                err;

  conv_tile_loader #(
    .Y(Y), .A_W(A_W), .M_W(M_W), .URAM_D_W(URAM_D_W), .URAM_A_W(URAM_A_W)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .uram1_wr_addr(uram1_wr_addr), .uram1_wr_data(uram1_wr_data),
    .uram1_wr_en(uram1_wr_en), .krnl_wraddr(krnl_wraddr), .krnl_wrdata(krnl_wrdata),
    .krnl_bram1_wren(krnl_bram1_wren), .krnl_bram2_wren(krnl_bram2_wren),
    .done(done), .err(err)
  );

  // kind: 0 = no write, 1 = URAM1, 2 = kernel bank1, 3 = kernel bank2
  typedef struct {
    int          kind;
    int          tile;
    logic [22:0] addr;
    logic [71:0] data;
    bit          dn;
    bit          er;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  passes = 0;
  int  total  = 0;
  int  cyc    = 0;
  int  ev_num = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [71:0] hdr(input logic [1:0] t, input logic [11:0] tile,
                                      input logic [22:0] base, input logic [15:0] n);
    return {t, tile, base, n, 19'h0};
  endfunction

  task automatic push_ev(input int kind, input int tile, input logic [22:0] addr,
                         input logic [71:0] data, input bit dn, input bit er, input int c);
    ev_t e;
    e.kind = kind; e.tile = tile; e.addr = addr; e.data = data;
    e.dn = dn; e.er = er; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Drive one stream word and hold it until accepted; returns the accept cycle.
  task automatic applyStimulus(input logic [71:0] d, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (s_ready) begin
        acc = cyc;
        got = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (!got) begin
      total++;
      $display("[TB] FAIL accept_timeout word=%h never accepted within 40 cycles", d);
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s got=%h want=%h", name, got, want);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with any enable/done/err must match the next expected event.
  always @(negedge clk) begin
    int          okind, otile, pop;
    logic [22:0] oaddr;
    logic [71:0] odata;
    ev_t         e;
    if ((|uram1_wr_en) || (|krnl_bram1_wren) || (|krnl_bram2_wren) || done || err) begin
      pop = $countones(uram1_wr_en) + $countones(krnl_bram1_wren) + $countones(krnl_bram2_wren);
      okind = 0; otile = 0; oaddr = '0; odata = '0;
      if (pop > 1)                okind = 9;
      else if (|uram1_wr_en)      okind = 1;
      else if (|krnl_bram1_wren)  okind = 2;
      else if (|krnl_bram2_wren)  okind = 3;
      for (int i = 0; i < Y; i++)
        if (uram1_wr_en[i] || krnl_bram1_wren[i] || krnl_bram2_wren[i]) otile = i;
      if (okind == 1) begin
        oaddr = uram1_wr_addr;
        odata = uram1_wr_data;
      end else if (okind == 2 || okind == 3) begin
        oaddr = 23'(krnl_wraddr);
        odata = 72'(krnl_wrdata);
      end
      total++;
      ev_num++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_event cyc=%0d kind=%0d tile=%0d addr=%h done=%b err=%b",
                 cyc, okind, otile, oaddr, done, err);
      end else begin
        e = exp_q.pop_front();
        if (okind == e.kind && (okind == 0 || otile == e.tile) && oaddr == e.addr &&
            odata == e.data && done == e.dn && err == e.er && cyc == e.cyc)
          passes++;
        else
          $display("[TB] FAIL event%0d got kind=%0d tile=%0d addr=%h data=%h done=%b err=%b cyc=%0d want kind=%0d tile=%0d addr=%h data=%h done=%b err=%b cyc=%0d",
                   ev_num, okind, otile, oaddr, odata, done, err, cyc,
                   e.kind, e.tile, e.addr, e.data, e.dn, e.er, e.cyc);
      end
    end
  end

  initial begin
    int a, a1, a2;
    logic [71:0] w1, w2, w3;

    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    idle(2);

    // Reset state: everything zero, ready low
    @(negedge clk);
    checkOutput("reset_ready", 128'(s_ready), 128'(0));
    checkOutput("reset_enables", 128'({|uram1_wr_en, |krnl_bram1_wren, |krnl_bram2_wren, done, err}), 128'(0));
    checkOutput("reset_addr", 128'({uram1_wr_addr, krnl_wraddr}), 128'(0));
    checkOutput("reset_data", 128'({uram1_wr_data, krnl_wrdata}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    checkOutput("ready_after_reset", 128'(s_ready), 128'(1));
    @(posedge clk); #1;

    // Image packet: tile 5, base 0x100, three back-to-back words
    applyStimulus(hdr(2'd0, 12'd5, 23'h100, 16'd3), a);
    applyStimulus(72'hAAAA_0000_0000_0000_01, a);
    push_ev(1, 5, 23'h100, 72'hAAAA_0000_0000_0000_01, 0, 0, a + 1);
    applyStimulus(72'hBBBB_0000_0000_0000_02, a);
    push_ev(1, 5, 23'h101, 72'hBBBB_0000_0000_0000_02, 0, 0, a + 1);
    applyStimulus(72'hCCCC_0000_0000_0000_03, a);
    push_ev(1, 5, 23'h102, 72'hCCCC_0000_0000_0000_03, 1, 0, a + 1);
    idle(3);

    // Kernel bank1: tile 0, base 10, two words, lanes in address order 10..17
    w1 = {18'h0D004, 18'h0C003, 18'h0B002, 18'h0A001};
    w2 = {18'h1D008, 18'h1C007, 18'h1B006, 18'h1A005};
    applyStimulus(hdr(2'd1, 12'd0, 23'd10, 16'd2), a);
    applyStimulus(w1, a1);
    push_ev(2, 0, 23'd10, 72'h0A001, 0, 0, a1 + 1);
    push_ev(2, 0, 23'd11, 72'h0B002, 0, 0, a1 + 2);
    push_ev(2, 0, 23'd12, 72'h0C003, 0, 0, a1 + 3);
    push_ev(2, 0, 23'd13, 72'h0D004, 0, 0, a1 + 4);
    applyStimulus(w2, a2);
    checkOutput("krn_word_spacing", 128'(a2 - a1), 128'(4));
    push_ev(2, 0, 23'd14, 72'h1A005, 0, 0, a2 + 1);
    push_ev(2, 0, 23'd15, 72'h1B006, 0, 0, a2 + 2);
    push_ev(2, 0, 23'd16, 72'h1C007, 0, 0, a2 + 3);
    push_ev(2, 0, 23'd17, 72'h1D008, 1, 0, a2 + 4);
    idle(6);

    // Legal header with N=0: done only
    applyStimulus(hdr(2'd1, 12'd3, 23'd0, 16'd0), a);
    push_ev(0, 0, 23'd0, 72'd0, 1, 0, a + 1);
    idle(2);

    // Illegal header (tile 480): err, two words dropped, done on the second
    applyStimulus(hdr(2'd0, 12'd480, 23'h40, 16'd2), a);
    push_ev(0, 0, 23'd0, 72'd0, 0, 1, a + 1);
    applyStimulus(72'h1111, a);
    applyStimulus(72'h2222, a);
    push_ev(0, 0, 23'd0, 72'd0, 1, 0, a + 1);
    // A following legal header is processed normally
    applyStimulus(hdr(2'd0, 12'd1, 23'h20, 16'd1), a);
    applyStimulus(72'h00DE_AD00_BEEF, a);
    push_ev(1, 1, 23'h20, 72'h00DE_AD00_BEEF, 1, 0, a + 1);
    idle(2);

    // Kernel bank2 address wrap at 2^A_W
    w3 = {18'h33334, 18'h33333, 18'h33332, 18'h33331};
    applyStimulus(hdr(2'd2, 12'd2, 23'h3FFE, 16'd1), a);
    applyStimulus(w3, a);
    push_ev(3, 2, 23'h3FFE, 72'h33331, 0, 0, a + 1);
    push_ev(3, 2, 23'h3FFF, 72'h33332, 0, 0, a + 2);
    push_ev(3, 2, 23'h0000, 72'h33333, 0, 0, a + 3);
    push_ev(3, 2, 23'h0001, 72'h33334, 1, 0, a + 4);
    idle(6);

    // Image with s_valid gaps, also wrapping the URAM address
    applyStimulus(hdr(2'd0, 12'd9, 23'h7FFFFE, 16'd4), a);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      applyStimulus(72'h5500 + 72'(i), a);
      push_ev(1, 9, 23'h7FFFFE + 23'(i), 72'h5500 + 72'(i), i == 3, 0, a + 1);
    end
    idle(3);

    // Mid-packet reset after the 2nd of 4 image words
    applyStimulus(hdr(2'd0, 12'd4, 23'h200, 16'd4), a);
    applyStimulus(72'h7701, a);
    push_ev(1, 4, 23'h200, 72'h7701, 0, 0, a + 1);
    applyStimulus(72'h7702, a);
    push_ev(1, 4, 23'h201, 72'h7702, 0, 0, a + 1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midrst_ready", 128'(s_ready), 128'(0));
    checkOutput("midrst_enables", 128'({|uram1_wr_en, |krnl_bram1_wren, |krnl_bram2_wren, done, err}), 128'(0));
    checkOutput("midrst_addr_data", 128'({uram1_wr_addr, krnl_wraddr, krnl_wrdata}), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    // The third word is now parsed as a header
    applyStimulus(hdr(2'd0, 12'd3, 23'h55, 16'd1), a);
    applyStimulus(72'h7704, a);
    push_ev(1, 3, 23'h55, 72'h7704, 1, 0, a + 1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    idle(3);
    checkOutput("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/conv_tile_loader.md
# conv_tile_loader

Upstream stage of `dsp_conv_chip`: consumes a single 72-bit valid/ready command stream and scatters image words into the per-tile URAM1 write ports and kernel weights into the per-tile kernel BRAM1/BRAM2 write ports. The address and data buses are shared across all Y tiles. Each target is selected by a one-hot write-enable vector, so only the addressed `dsp_conv_top` tile sees a write. A packet is one header word followed by N payload words.

## Interface
Parameters:
- Y, 480, number of conv tiles; must be at most 4096.
- A_W, 14, kernel BRAM address width.
- M_W, 18, kernel weight width; 4*M_W must not exceed URAM_D_W.
- URAM_D_W, 72, stream and URAM data width.
- URAM_A_W, 23, URAM address width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  URAM_D_W  stream word (header or payload).
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader can accept; a transfer occurs when s_valid&&s_ready.
- uram1_wr_addr  out  URAM_A_W  shared URAM1 write address.
- uram1_wr_data  out  URAM_D_W  shared URAM1 write data.
- uram1_wr_en  out  Y  one-hot URAM1 write enable, bit i = tile i.
- krnl_wraddr  out  A_W  shared kernel BRAM address (drives both banks).
- krnl_wrdata  out  M_W  shared kernel weight.
- krnl_bram1_wren  out  Y  one-hot bank-1 write enable.
- krnl_bram2_wren  out  Y  one-hot bank-2 write enable.
- done  out  1  one-cycle pulse when a packet's last write issues (or its last dropped word is consumed).
- err  out  1  one-cycle pulse on accepting an illegal header.

## Operation
Header fields:
- [71:70] type: 0 = image, 1 = kernel bank1, 2 = kernel bank2, 3 = illegal.
- [69:58] tile index.
- [57:35] base address.
- [34:19] N, the payload word count.
- Remaining bits are ignored.

FSM states: HDR, IMG, KRN, DROP.
- **HDR:** s_ready=1. On header accept, latch type, tile, base and N.
  - type=3 or tile>=Y: go to DROP (or stay in HDR if N=0) and pulse err.
  - N=0 with a legal header: stay in HDR, pulse done, issue no writes.
  - Otherwise go to IMG (type 0) or KRN (types 1 and 2).
- **IMG:** s_ready=1.
  - Each accepted word writes to URAM1 of the latched tile at address base+k, for k=0..N-1.
  - Address wraps modulo 2^URAM_A_W.
  - After word N-1, return to HDR.
- **KRN:** each accepted word yields 4 weights in lane order: bits [M_W-1:0] first, then [2M_W-1:M_W], and so on.
  - Weights go to the selected bank of the latched tile at address base+4k+lane.
  - The low A_W bits of the header base are used; address wraps modulo 2^A_W.
  - After the last lane of word N-1, return to HDR.
- **DROP:** s_ready=1. Consume N words with no writes, pulse done on the last one, return to HDR.
- Exactly one enable bit, across all three enable vectors, is high in any cycle; all enables are 0 otherwise.
- When enables are 0, address and data outputs hold their last values. Their values are don't-care.

## Timing
- **Reset:** rst=1 forces HDR. s_ready, all wr_en vectors, done, err, addresses and data are 0 on the cycle after rst is sampled high.
- **Mid-packet reset:** rst mid-packet abandons the packet. The remaining payload words are then parsed as a header.
- **Write outputs:** all registered.
- **IMG timing:**
  - A payload word accepted in cycle t produces its write strobe at t+1.
  - Throughput is 1 word per cycle. A gap in s_valid produces a gap in strobes.
- **KRN timing:**
  - A word accepted at t produces its lane 0..3 strobes at t+1..t+4.
  - s_ready=0 during t+1..t+3 and returns to 1 at t+4.
  - A next word accepted at t+4 strobes from t+5 on, giving a sustained 1 word per 4 cycles.
- **Strobe pulses:**
  - done coincides with the final write strobe.
  - err is asserted at t+1 after the header is accepted at t.
- **Header to payload:** a header accepted at t allows the first payload word to be accepted at t+1.

## Test plan
- **Image packet:** header type0, tile 5, base 0x100, N=3, payloads A/B/C back-to-back.
  - Expect uram1_wr_en=1<<5 for 3 cycles at addresses 0x100/0x101/0x102 with data A/B/C.
  - Expect done with the third strobe.
- **Kernel bank1:** header type1, tile 0, base 10, N=2.
  - Expect 8 bank1 strobes at addresses 10..17 carrying lanes in order.
  - Expect s_ready low 3 of every 4 cycles; bank2 stays 0.
- **Illegal header:** tile 480 (Y=480), N=2.
  - Expect err pulse, 2 words consumed, no enables, done on the second word.
  - A following legal header is then processed normally.
- **Wrap:** type2, base 0x3FFE (A_W=14), N=1 → addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- **Backpressure and gaps:** image N=4 with s_valid toggling every cycle.
  - Expect 4 strobes, each exactly 1 cycle after its accept, with addresses consecutive.
- **Mid-packet reset:** rst asserted after the 2nd of 4 image words.
  - Expect all outputs 0 next cycle and no further writes.
  - The next word is treated as a header.
